// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
// Shares one external 32-bit combinational ALU between two requesters using
// round-robin arbitration. An accepted operation is held in operand registers,
// presented to the ALU for one cycle, and the registered result is returned
// with the requester id through a valid/ready response handshake.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/op     request handshake and operands, N = 0,1
//   alu_a, alu_b, alu_op        registered operands to the external ALU
//   alu_result/flag/carry       ALU outputs (result, zero flag, carry)
//   resp_valid/ready            response handshake
//   resp_id/result/flag/carry   registered response payload
//   grant_cnt0/1                saturating per-port grant counters
//                               (only with ALU_RR_ARBITER_STATS_EN defined)
//
// States:
//   state | meaning
//   IDLE  | arbitrate between requesters, accept one operation
//   EXEC  | operand registers drive the ALU, result captured at cycle end
//   RESP  | response held until the consumer accepts it
module alu_rr_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_flag,
    input  logic           alu_carry,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [W-1:0]   resp_result,
    output logic           resp_flag,
    output logic           resp_carry
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]    grant_cnt0,
    output logic [15:0]    grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q;
    logic [W-1:0]   opa_q, opb_q;
    logic [OPW-1:0] opc_q;
    logic           id_q;
    logic           gnt0, gnt1;

    // A lone requester always wins; on a tie the port that did not win last time wins.
    assign gnt0 = req0_valid && (!req1_valid || last_grant_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_grant_q);

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (gnt0 || gnt1) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            id_q         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_result  <= '0;
            resp_flag    <= 1'b0;
            resp_carry   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req0_ready) begin
                opa_q        <= req0_a;
                opb_q        <= req0_b;
                opc_q        <= req0_op;
                id_q         <= 1'b0;
                last_grant_q <= 1'b0;
            end else if (req1_ready) begin
                opa_q        <= req1_a;
                opb_q        <= req1_b;
                opc_q        <= req1_op;
                id_q         <= 1'b1;
                last_grant_q <= 1'b1;
            end
            if (state_q == EXEC) begin
                resp_valid  <= 1'b1;
                resp_result <= alu_result;
                resp_flag   <= alu_flag;
                resp_carry  <= alu_carry;
            end else if (state_q == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Operand registers only change on a handshake, so the ALU inputs are
    // stable through EXEC and keep their last values afterwards.
    assign alu_a   = opa_q;
    assign alu_b   = opb_q;
    assign alu_op  = opc_q;
    assign resp_id = id_q;

`ifdef ALU_RR_ARBITER_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_flag, alu_carry;
    logic        resp_valid, resp_ready, resp_id, resp_flag, resp_carry;
    logic [31:0] resp_result;
`ifdef ALU_RR_ARBITER_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    int m_last = 1;   // reference model: port that won the previous grant

    // observations filled by run_txn
    logic        o_r0, o_r1, o_busy_rdy, o_lat_ok, o_stable;
    logic [31:0] o_ex_a, o_ex_b, o_res;
    logic [3:0]  o_ex_op;
    logic        o_id, o_fl, o_cy;

    always #5 clk = ~clk;

    alu_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flag(alu_flag), .alu_carry(alu_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flag(resp_flag), .resp_carry(resp_carry)
`ifdef ALU_RR_ARBITER_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // Behavioural ALU: {carry, result}
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] r;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, a} - {1'b0, b};
            4'd2:    r = {1'b0, a & b};
            4'd3:    r = {1'b0, a | b};
            4'd4:    r = {1'b0, a ^ b};
            4'd5:    r = {1'b0, a << b[4:0]};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    always_comb begin
        logic [32:0] r;
        r          = alu_model(alu_a, alu_b, alu_op);
        alu_result = r[31:0];
        alu_carry  = r[32];
        alu_flag   = (r[31:0] == 32'd0);
    end

    function automatic int exp_grant(input logic v0, input logic v1, input int last);
        if (v0 && v1) return 1 - last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Drives one operation starting just after a negedge, collects what the
    // DUT shows through EXEC/RESP, holds resp_ready low for 'hold' cycles.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                           input int hold, input logic keep_valid);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        resp_ready = 1'b0;
        #1;
        o_r0 = req0_ready; o_r1 = req1_ready;
        o_busy_rdy = 1'b0; o_lat_ok = 1'b1; o_stable = 1'b1;
        @(negedge clk);
        if (!keep_valid) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_op = 4'($urandom); req1_op = 4'($urandom);
        #1;
        o_ex_a = alu_a; o_ex_b = alu_b; o_ex_op = alu_op;
        if (req0_ready || req1_ready) o_busy_rdy = 1'b1;
        if (resp_valid) o_lat_ok = 1'b0;
        @(negedge clk);
        #1;
        if (!resp_valid) o_lat_ok = 1'b0;
        if (req0_ready || req1_ready) o_busy_rdy = 1'b1;
        o_id = resp_id; o_res = resp_result; o_fl = resp_flag; o_cy = resp_carry;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            #1;
            if (req0_ready || req1_ready) o_busy_rdy = 1'b1;
            if (!resp_valid || resp_id !== o_id || resp_result !== o_res ||
                resp_flag !== o_fl || resp_carry !== o_cy) o_stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
        checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL reset_resp_id got %0b exp 0", resp_id); end
        checks++; if ({resp_result, resp_flag, resp_carry} !== 34'd0) begin errors++; $display("FAIL reset_resp_payload got %h/%b/%b exp 0", resp_result, resp_flag, resp_carry); end
        checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin errors++; $display("FAIL reset_alu got %h/%h/%h exp 0", alu_a, alu_b, alu_op); end
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready got %b%b exp 00", req0_ready, req1_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_add;
        run_txn(1'b1, 1'b0, 32'h5, 32'h3, OP_ADD, 32'h0, 32'h0, 4'd0, 0, 1'b0);
        checks++; if (o_r0 !== 1'b1 || o_r1 !== 1'b0) begin errors++; $display("FAIL add_ready got %b%b exp 10", o_r0, o_r1); end
        checks++; if (o_lat_ok !== 1'b1) begin errors++; $display("FAIL add_latency got %b exp 1", o_lat_ok); end
        checks++; if (o_ex_a !== 32'h5 || o_ex_b !== 32'h3 || o_ex_op !== OP_ADD) begin errors++; $display("FAIL add_alu_in got %h/%h/%h exp 5/3/0", o_ex_a, o_ex_b, o_ex_op); end
        checks++; if (o_id !== 1'b0) begin errors++; $display("FAIL add_id got %0b exp 0", o_id); end
        checks++; if (o_res !== 32'd8) begin errors++; $display("FAIL add_result got %h exp 8", o_res); end
        checks++; if (o_fl !== 1'b0 || o_cy !== 1'b0) begin errors++; $display("FAIL add_flags got %b%b exp 00", o_fl, o_cy); end
        m_last = 0;
    endtask

    task automatic test_zero_result;
        run_txn(1'b0, 1'b1, 32'h0, 32'h0, 4'd0, 32'h1234_5678, 32'h1234_5678, OP_SUB, 0, 1'b0);
        checks++; if (o_r1 !== 1'b1 || o_r0 !== 1'b0) begin errors++; $display("FAIL zero_ready got %b%b exp 01", o_r0, o_r1); end
        checks++; if (o_id !== 1'b1) begin errors++; $display("FAIL zero_id got %0b exp 1", o_id); end
        checks++; if (o_res !== 32'd0) begin errors++; $display("FAIL zero_result got %h exp 0", o_res); end
        checks++; if (o_fl !== 1'b1) begin errors++; $display("FAIL zero_flag got %b exp 1", o_fl); end
        m_last = 1;
    endtask

    task automatic test_fairness;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a0, b0, a1, b1;
            logic [32:0] e;
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            run_txn(1'b1, 1'b1, a0, b0, OP_ADD, a1, b1, OP_SUB, 0, 1'b1);
            e = (i % 2 == 0) ? alu_model(a0, b0, OP_ADD) : alu_model(a1, b1, OP_SUB);
            checks++; if (o_r0 && o_r1) begin errors++; $display("FAIL fair_both_ready[%0d] got 11 exp one-hot", i); end
            checks++; if (o_id !== 1'(i % 2) || o_r0 !== 1'(i % 2 == 0)) begin errors++; $display("FAIL fair_grant[%0d] got id %0b r0 %0b exp %0d", i, o_id, o_r0, i % 2); end
            checks++; if ({o_cy, o_res} !== e) begin errors++; $display("FAIL fair_result[%0d] got %h exp %h", i, {o_cy, o_res}, e); end
            checks++; if (o_busy_rdy !== 1'b0) begin errors++; $display("FAIL fair_busy_ready[%0d] got 1 exp 0", i); end
            m_last = i % 2;
        end
    endtask

    task automatic test_backpressure;
        int g;
        g = exp_grant(1'b1, 1'b1, m_last);
        run_txn(1'b1, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 4'd3, 32'h1, 32'h2, OP_ADD, 5, 1'b1);
        checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", o_stable); end
        checks++; if (o_busy_rdy !== 1'b0) begin errors++; $display("FAIL bp_busy_ready got 1 exp 0"); end
        checks++; if (o_id !== 1'(g)) begin errors++; $display("FAIL bp_id got %0b exp %0d", o_id, g); end
        m_last = g;
        g = exp_grant(1'b1, 1'b1, m_last);
        run_txn(1'b1, 1'b1, 32'h7, 32'h7, OP_SUB, 32'h9, 32'h1, OP_SUB, 0, 1'b0);
        checks++; if (o_r0 !== 1'(g == 0) || o_r1 !== 1'(g == 1)) begin errors++; $display("FAIL bp_next_grant got %b%b exp port %0d", o_r0, o_r1, g); end
        m_last = g;
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int v, g, hold;
            logic [31:0] a0, b0, a1, b1;
            logic [3:0] op0, op1;
            logic [32:0] e;
            logic [31:0] ea;
            v = $urandom_range(0, 3);
            if (v == 0) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                req0_a = $urandom; req1_a = $urandom;
                #1;
                checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rnd_idle_ready[%0d] got %b%b exp 00", i, req0_ready, req1_ready); end
                @(negedge clk);
                continue;
            end
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            if ($urandom_range(0, 3) == 0) b0 = a0;
            op0 = 4'($urandom_range(0, 7)); op1 = 4'($urandom_range(0, 7));
            hold = $urandom_range(0, 2);
            g = exp_grant(v[0], v[1], m_last);
            e  = (g == 0) ? alu_model(a0, b0, op0) : alu_model(a1, b1, op1);
            ea = (g == 0) ? a0 : a1;
            run_txn(v[0], v[1], a0, b0, op0, a1, b1, op1, hold, 1'($urandom_range(0, 1)));
            checks++; if (o_r0 !== 1'(g == 0) || o_r1 !== 1'(g == 1)) begin errors++; $display("FAIL rnd_grant[%0d] got %b%b exp port %0d", i, o_r0, o_r1, g); end
            checks++; if (o_ex_a !== ea) begin errors++; $display("FAIL rnd_alu_a[%0d] got %h exp %h", i, o_ex_a, ea); end
            checks++; if (o_lat_ok !== 1'b1 || o_stable !== 1'b1 || o_busy_rdy !== 1'b0) begin errors++; $display("FAIL rnd_proto[%0d] got lat %b stable %b busy %b exp 1 1 0", i, o_lat_ok, o_stable, o_busy_rdy); end
            checks++; if (o_id !== 1'(g)) begin errors++; $display("FAIL rnd_id[%0d] got %0b exp %0d", i, o_id, g); end
            checks++; if ({o_cy, o_res} !== e || o_fl !== (e[31:0] == 32'd0)) begin errors++; $display("FAIL rnd_result[%0d] got %h/%b exp %h/%b", i, {o_cy, o_res}, o_fl, e, e[31:0] == 32'd0); end
            m_last = g;
        end
    endtask

    task automatic test_async_reset;
        req0_valid = 1'b1; req0_a = 32'hA5A5_0001; req0_b = 32'h0000_0101; req0_op = OP_ADD;
        req1_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (alu_a !== 32'hA5A5_0001) begin errors++; $display("FAIL arst_exec_alu_a got %h exp a5a50001", alu_a); end
        rst_n = 1'b0;
        #1;
        checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin errors++; $display("FAIL arst_alu got %h/%h/%h exp 0", alu_a, alu_b, alu_op); end
        checks++; if (resp_valid !== 1'b0 || resp_result !== 32'd0 || resp_id !== 1'b0) begin errors++; $display("FAIL arst_resp got %b/%h/%b exp 0", resp_valid, resp_result, resp_id); end
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL arst_no_resp[%0d] got 1 exp 0", k); end
        end
        run_txn(1'b1, 1'b1, 32'h10, 32'h20, OP_ADD, 32'h30, 32'h40, OP_ADD, 0, 1'b0);
        checks++; if (o_r0 !== 1'b1 || o_r1 !== 1'b0 || o_id !== 1'b0) begin errors++; $display("FAIL arst_first_tie got %b%b id %0b exp 10 id 0", o_r0, o_r1, o_id); end
        checks++; if (o_res !== 32'h30) begin errors++; $display("FAIL arst_first_result got %h exp 30", o_res); end
        m_last = 0;
    endtask

`ifdef ALU_RR_ARBITER_STATS_EN
    task automatic test_stats;
        rst_n = 1'b0;
        #2;
        checks++; if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", grant_cnt0, grant_cnt1); end
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
        for (int i = 0; i < 5; i++) begin
            run_txn(1'(i < 3), 1'(i >= 3), $urandom, $urandom, OP_ADD, $urandom, $urandom, OP_ADD, 0, 1'b0);
        end
        checks++; if (grant_cnt0 !== 16'd3 || grant_cnt1 !== 16'd2) begin errors++; $display("FAIL stats_count got %0d/%0d exp 3/2", grant_cnt0, grant_cnt1); end
        force dut.cnt0_q = 16'hFFFE;
        #1;
        release dut.cnt0_q;
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b1, 1'b0, $urandom, $urandom, OP_ADD, 32'h0, 32'h0, OP_ADD, 0, 1'b0);
        end
        checks++; if (grant_cnt0 !== 16'hFFFF || grant_cnt1 !== 16'd2) begin errors++; $display("FAIL stats_saturate got %h/%0d exp ffff/2", grant_cnt0, grant_cnt1); end
        m_last = 0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        @(negedge clk);
        test_reset();
        test_single_add();
        test_zero_result();
        test_fairness();
        test_backpressure();
        test_random();
        test_async_reset();
`ifdef ALU_RR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached before end of test sequence");
        $fatal(1, "timeout");
    end

endmodule
